// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller.
// Detects the start edge, runs the downstream-of-sampler frame walk (start, data, optional
// parity, stop), deserializes LSB-first, checks parity/stop and strobes out validated bytes.
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic [PRESC_W-1:0]    edge_cnt,
  input  logic [3:0]            bit_cnt,
  input  logic                  sampled_bit,
  input  logic                  Sample_Available,
  output logic                  enable,
  output logic                  data_samp_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } state_e;

  localparam logic [3:0] LastDataBit = 4'(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  data_valid_q, data_valid_d;
  logic                  active_q, active_d;
  // Frame configuration is captured when the start edge is seen so that a change of
  // PAR_EN/PAR_TYP/Prescale only affects the next frame.
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;

  logic [PRESC_W-1:0]    presc_m1;
  logic                  bnd;

  assign presc_m1 = presc_q - PRESC_W'(1);
  // Last sampler edge of the current bit.
  assign bnd      = active_q && (edge_cnt == presc_m1);

  // Next-state, shift register, error flags and captured frame configuration.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    presc_d   = presc_q;

    unique case (state_q)
      StIdle: begin
        if (!RX_IN) begin
          state_d   = StStart;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          presc_d   = Prescale;
        end
      end

      StStart: begin
        // A high start-bit sample means the falling edge was a glitch.
        if (Sample_Available && sampled_bit) begin
          state_d = StIdle;
        end else if (bnd) begin
          state_d = StData;
        end
      end

      StData: begin
        // Shift right so the first data bit lands in bit 0.
        if (Sample_Available) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        end
        if (bnd && (bit_cnt == LastDataBit)) begin
          state_d = par_en_q ? StParity : StStop;
        end
      end

      StParity: begin
        if (Sample_Available) begin
          par_err_d = sampled_bit ^ (^shift_q) ^ par_typ_q;
        end
        if (bnd) begin
          state_d = StStop;
        end
      end

      StStop: begin
        // Leave mid stop bit: half a bit of slack for a following start edge.
        if (Sample_Available) begin
          stp_err_d = ~sampled_bit;
          state_d   = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs: sampler enables follow the next state, the byte strobe follows DONE.
  always_comb begin
    active_d     = (state_d == StStart) || (state_d == StData) ||
                   (state_d == StParity) || (state_d == StStop);
    data_valid_d = (state_q == StDone) && !par_err_q && !stp_err_q;
    p_data_d     = data_valid_d ? shift_q : p_data_q;
  end

  // All state, including outputs, with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      p_data_q     <= '0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      data_valid_q <= 1'b0;
      active_q     <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      presc_q      <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      data_valid_q <= data_valid_d;
      active_q     <= active_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      presc_q      <= presc_d;
    end
  end

  assign enable       = active_q;
  assign data_samp_en = active_q;
  assign P_DATA       = p_data_q;
  assign data_valid   = data_valid_q;
  assign par_err      = par_err_q;
  assign stp_err      = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: an edge-counter/sampler model feeds the DUT, frames are
// driven on RX_IN, and per-frame outcomes are compared against a frame-level model.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [PW-1:0] Prescale = 5'd8;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          sampled_bit;
  logic          Sample_Available;
  logic          enable;
  logic          data_samp_en;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  uart_rx_frame_ctrl #(
    .DATA_WIDTH(DW),
    .PRESC_W   (PW)
  ) u_dut (
    .CLK             (CLK),
    .RST             (RST),
    .RX_IN           (RX_IN),
    .PAR_EN          (PAR_EN),
    .PAR_TYP         (PAR_TYP),
    .Prescale        (Prescale),
    .edge_cnt        (edge_cnt),
    .bit_cnt         (bit_cnt),
    .sampled_bit     (sampled_bit),
    .Sample_Available(Sample_Available),
    .enable          (enable),
    .data_samp_en    (data_samp_en),
    .P_DATA          (P_DATA),
    .data_valid      (data_valid),
    .par_err         (par_err),
    .stp_err         (stp_err)
  );

  always #5 CLK = ~CLK;

  // Upstream sampler model: counts edges/bits while enabled, samples at mid-bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      sampled_bit <= 1'b1;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (edge_cnt == Prescale - 5'd1) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 5'd1;
      end
      if (edge_cnt == (Prescale >> 1)) sampled_bit <= RX_IN;
    end
  end

  assign Sample_Available = enable && (edge_cnt == (Prescale >> 1) + 5'd1);

  typedef struct {
    logic          dv;
    logic [DW-1:0] pd;
    logic          pe;
    logic          se;
  } res_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          par_en;
    logic          par_typ;
    logic [PW-1:0] presc;
    logic          par_bit;
    logic          stop_bit;
    int            gap;
    logic          exp_dv;
    logic [DW-1:0] exp_pd;
    logic          exp_pe;
    logic          exp_se;
  } vec_t;

  int        checks = 0;
  int        failures = 0;
  int        cyc = 0;
  int        dv_total = 0;
  int        exp_dv_total = 0;
  int        stop_cyc = 0;
  logic      stop_pend = 1'b0;
  logic [3:0] stop_idx = 4'd9;
  res_t      res_q[$];
  res_t      exp_q[$];
  int        res_base = 0;
  vec_t      vecs[8];
  logic [DW-1:0] last_good = '0;

  function automatic res_t mk_res(input logic dv, input logic [DW-1:0] pd, input logic pe,
                                  input logic se);
    mk_res.dv = dv;
    mk_res.pd = pd;
    mk_res.pe = pe;
    mk_res.se = se;
  endfunction

  always_ff @(posedge CLK) cyc <= cyc + 1;

  // Monitor: count strobes; snapshot outputs two cycles after the stop-bit sample.
  always @(negedge CLK) begin
    if (!RST) begin
      stop_pend <= 1'b0;
    end else begin
      if (data_valid) dv_total <= dv_total + 1;
      if (Sample_Available && (bit_cnt == stop_idx)) begin
        stop_cyc  <= cyc;
        stop_pend <= 1'b1;
      end else if (stop_pend && (cyc == stop_cyc + 2)) begin
        res_q.push_back(mk_res(data_valid, P_DATA, par_err, stp_err));
        stop_pend <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic [PW-1:0] p, input logic pbit, input logic sbit,
                            input int gap);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    Prescale = p;
    stop_idx = pe ? 4'd10 : 4'd9;
    drive_bit(1'b0, int'(p));
    for (int i = 0; i < DW; i++) drive_bit(d[i], int'(p));
    if (pe) drive_bit(pbit, int'(p));
    drive_bit(sbit, int'(p));
    RX_IN = 1'b1;
    repeat (gap) @(posedge CLK);
    #1;
  endtask

  task automatic check_results(input string tag);
    int n;
    n = res_q.size() - res_base;
    check({tag, "_frames"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < n) begin
        check($sformatf("%s_%0d_dv", tag, i), 32'(res_q[res_base+i].dv), 32'(exp_q[i].dv));
        check($sformatf("%s_%0d_pdata", tag, i), 32'(res_q[res_base+i].pd), 32'(exp_q[i].pd));
        check($sformatf("%s_%0d_par_err", tag, i), 32'(res_q[res_base+i].pe),
              32'(exp_q[i].pe));
        check($sformatf("%s_%0d_stp_err", tag, i), 32'(res_q[res_base+i].se),
              32'(exp_q[i].se));
      end
    end
    res_base = res_q.size();
    exp_q.delete();
  endtask

  initial begin
    // data, par_en, par_typ, presc, par_bit, stop_bit, gap, exp dv/pdata/par_err/stp_err
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 5'd8,  1'b0, 1'b1, 16, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 5'd8,  1'b1, 1'b1, 16, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 5'd8,  1'b0, 1'b1, 16, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0, 32, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 5'd16, 1'b0, 1'b1, 0,  1'b1, 8'h55, 1'b0, 1'b0};
    vecs[5] = '{8'hAA, 1'b0, 1'b0, 5'd16, 1'b0, 1'b1, 16, 1'b1, 8'hAA, 1'b0, 1'b0};
    vecs[6] = '{8'h07, 1'b1, 1'b1, 5'd8,  1'b0, 1'b1, 16, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[7] = '{8'h07, 1'b1, 1'b1, 5'd8,  1'b1, 1'b1, 16, 1'b0, 8'h07, 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_samp_en", 32'(data_samp_en), 32'd0);
    check("rst_pdata", 32'(P_DATA), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    check("rst_stp_err", 32'(stp_err), 32'd0);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Directed frames.
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].presc,
                 vecs[i].par_bit, vecs[i].stop_bit, vecs[i].gap);
      exp_q.push_back(mk_res(vecs[i].exp_dv, vecs[i].exp_pd, vecs[i].exp_pe, vecs[i].exp_se));
      if (vecs[i].exp_dv) exp_dv_total++;
    end
    repeat (8) @(posedge CLK);
    #1;
    check_results("tbl");
    check("tbl_dv_pulses", 32'(dv_total), 32'(exp_dv_total));
    last_good = 8'h07;

    // Start glitch: line low for 3 cycles only.
    PAR_EN   = 1'b0;
    Prescale = 5'd8;
    stop_idx = 4'd9;
    RX_IN    = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("glitch_enable_on", 32'(enable), 32'd1);
    RX_IN = 1'b1;
    repeat (16) @(posedge CLK);
    #1;
    check("glitch_enable_off", 32'(enable), 32'd0);
    check("glitch_samp_en_off", 32'(data_samp_en), 32'd0);
    check("glitch_par_err", 32'(par_err), 32'd0);
    check("glitch_stp_err", 32'(stp_err), 32'd0);
    check("glitch_pdata", 32'(P_DATA), 32'(last_good));
    check("glitch_dv_pulses", 32'(dv_total), 32'(exp_dv_total));
    check("glitch_frames", 32'(res_q.size() - res_base), 32'd0);

    // Reset in the middle of DATA of 0xF0.
    drive_bit(1'b0, 8);
    for (int i = 0; i < 5; i++) drive_bit(((8'hF0 >> i) & 8'h01) != 0, 8);
    check("mid_enable_before_rst", 32'(enable), 32'd1);
    #2 RST = 1'b0;
    #1;
    check("async_rst_enable", 32'(enable), 32'd0);
    check("async_rst_samp_en", 32'(data_samp_en), 32'd0);
    check("async_rst_pdata", 32'(P_DATA), 32'd0);
    check("async_rst_dv", 32'(data_valid), 32'd0);
    check("async_rst_par_err", 32'(par_err), 32'd0);
    check("async_rst_stp_err", 32'(stp_err), 32'd0);
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    send_frame(8'h12, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1, 8);
    exp_q.push_back(mk_res(1'b1, 8'h12, 1'b0, 1'b0));
    exp_dv_total++;
    last_good = 8'h12;
    repeat (4) @(posedge CLK);
    #1;
    check_results("post_rst");
    check("post_rst_dv_pulses", 32'(dv_total), 32'(exp_dv_total));

    // Randomized frames against the frame-level model.
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] d;
      logic          pe, pt, corrupt, sbit, good_par, pbit, exp_pe, exp_se;
      logic [PW-1:0] p;
      int            gap;
      d        = DW'($urandom);
      pe       = 1'($urandom_range(0, 1));
      pt       = 1'($urandom_range(0, 1));
      p        = ($urandom_range(0, 1) != 0) ? 5'd16 : 5'd8;
      corrupt  = ($urandom_range(0, 3) == 0);
      sbit     = ($urandom_range(0, 4) != 0);
      // Parity bit value that makes the ones count even (PAR_TYP=0) or odd (PAR_TYP=1).
      good_par = (^d) ^ pt;
      pbit     = good_par ^ corrupt;
      exp_pe   = pe & corrupt;
      exp_se   = ~sbit;
      gap      = sbit ? int'($urandom_range(0, 2 * int'(p)))
                      : 2 * int'(p) + int'($urandom_range(0, int'(p)));
      send_frame(d, pe, pt, p, pbit, sbit, gap);
      if (!exp_pe && !exp_se) begin
        last_good = d;
        exp_dv_total++;
      end
      exp_q.push_back(mk_res(!exp_pe && !exp_se, last_good, exp_pe, exp_se));
    end
    repeat (48) @(posedge CLK);
    #1;
    check_results("rnd");
    check("rnd_dv_pulses", 32'(dv_total), 32'(exp_dv_total));
    check("rnd_idle_enable", 32'(enable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame-level controller for the UART receiver. It sits directly downstream of the edge counter / data sampler. It detects the start edge and enables the sampler. It walks the frame (start, data, optional parity, stop) using the sampler's edge_cnt, bit_cnt and Sample_Available outputs, deserializes sampled_bit LSB-first, checks parity and stop, and presents a validated byte with a one-cycle data_valid strobe.

Parameters:
DATA_WIDTH  8  data bits per frame; legal range 5..8
PRESC_W     5  width of Prescale and edge_cnt

Ports:
CLK               in   1           system clock; every register is on its rising edge
RST               in   1           asynchronous, active-low reset
RX_IN             in   1           serial line, already synchronous to CLK, idle high
PAR_EN            in   1           1 = frame carries a parity bit
PAR_TYP           in   1           0 = even parity, 1 = odd parity
Prescale          in   PRESC_W     CLK cycles per bit; legal values 8 and 16
edge_cnt          in   PRESC_W     from sampler; 0..Prescale-1 while enable=1; 0 while enable=0
bit_cnt           in   4           from sampler; 0 = start bit, increments when edge_cnt==Prescale-1
sampled_bit       in   1           majority-voted bit value; meaningful only when Sample_Available=1
Sample_Available  in   1           one-cycle pulse, one per bit, before edge_cnt reaches Prescale-1
enable            out  1           runs the sampler's edge/bit counters
data_samp_en      out  1           enables majority sampling
P_DATA            out  DATA_WIDTH  last good byte
data_valid        out  1           one-cycle strobe, P_DATA updated in the same cycle
par_err           out  1           parity error of the current/last frame
stp_err           out  1           stop-bit error of the current/last frame

Behaviour:
- Reset (RST=0, async): state=IDLE. enable, data_samp_en, data_valid, par_err, stp_err = 0. P_DATA = 0. Internal shift register = 0. Reset mid-frame aborts the frame; no data_valid is produced.
- Bit boundary: bnd = enable & (edge_cnt == Prescale-1).
- States: IDLE, START, DATA, PARITY, STOP, DONE. Outputs are registered, Moore-style, from the state. enable = data_samp_en = 1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
- IDLE: RX_IN==0 -> START on the next edge. par_err and stp_err are cleared on this transition and otherwise hold their last value.
- START:
  - Sample_Available & sampled_bit==1 -> IDLE (glitch). No error flags are set and no data_valid is produced.
  - Otherwise, bnd -> DATA.
- DATA:
  - Each Sample_Available shifts sampled_bit in at the MSB (shift right), so the first data bit ends up in bit 0 after DATA_WIDTH samples.
  - bnd & bit_cnt==DATA_WIDTH -> PARITY if PAR_EN, else STOP.
- PARITY: on Sample_Available, par_err <= sampled_bit ^ (^shift) ^ PAR_TYP. bnd -> STOP.
- STOP: on Sample_Available, stp_err <= ~sampled_bit and go to DONE on the next edge. The controller does not wait for the end of the stop bit; this gives a half-bit margin for back-to-back frames.
- DONE: lasts one cycle, then IDLE.
  - If the par_err and stp_err values set in this frame are both 0: P_DATA <= shift and data_valid=1 for exactly this one cycle.
  - Otherwise P_DATA holds and data_valid stays 0.
- Latency: data_valid rises 2 CLK cycles after the stop-bit Sample_Available pulse.
- PAR_EN, PAR_TYP and Prescale are static during a frame. Changes take effect at the next IDLE->START transition. Behaviour under mid-frame changes is undefined.
- RX_IN low while in DONE: detected in IDLE on the following cycle, with no frame loss.
- Stop error with RX_IN held low (break condition): DONE -> IDLE -> START immediately. The resulting frame is processed normally (glitch or data).
- bnd and Sample_Available in the same cycle: the sample is taken first, then the transition. The sampler contract forbids this combination; the controller still handles it.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame start/0xA5 LSB-first/parity 0/stop 1 -> data_valid single pulse, P_DATA=0xA5, par_err=0, stp_err=0.
- Same frame with parity bit 1 -> no data_valid, par_err=1, P_DATA keeps the previous value (0xA5). Next clean frame 0x3C -> par_err cleared at its start, P_DATA=0x3C.
- PAR_EN=0, Prescale=16, byte 0x81 with stop bit 0 -> stp_err=1, no data_valid. Then two back-to-back good frames 0x55 and 0xAA with no idle gap -> two data_valid pulses carrying 0x55 then 0xAA.
- RX_IN low for 3 cycles then high (Prescale=8) -> sampled_bit=1 in START -> return to IDLE, enable=0, no error flags, no data_valid.
- PAR_TYP=1 (odd), byte 0x07, parity bit 0 -> P_DATA=0x07, par_err=0. Same byte with parity bit 1 -> par_err=1.
- Assert RST during DATA of frame 0xF0 -> all outputs 0 immediately (asynchronously). After release, a full frame 0x12 is received correctly.
